ir_fetch_unit: RTL and testbench
================================

Name: ir_fetch_unit

Overview:
Fetch stage and instruction register for the multicycle CPU, directly upstream of the sign extender. It holds the PC and runs a req/ack read of instruction memory on command from the main control FSM. It latches the returned word into IR, advances PC by 4, and breaks IR into decode fields; imm16 drives the sign extender input. A watchdog counter flags a memory that never acknowledges.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 16, maximum cycles mem_req may stay high without mem_ack before fault; 0 disables the watchdog
WAIT_W, 8, width of the wait counter; must hold MAX_WAIT

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
fetch_start  in  1  control FSM request to fetch the instruction at pc
pc_write  in  1  load pc from pc_next (branch/jump)
pc_next  in  32  new PC value
mem_req  out  1  instruction memory read request
mem_addr  out  32  read address, word aligned
mem_ack  in  1  memory has placed data on mem_rdata this cycle
mem_rdata  in  32  instruction word
pc  out  32  current PC
pc_plus4  out  32  pc + 4, combinational
ir  out  32  instruction register
ir_valid  out  1  ir holds a completed fetch
busy  out  1  fetch in progress
fault  out  1  watchdog expired; sticky until reset
opcode  out  6  ir[31:26]
rs  out  5  ir[25:21]
rt  out  5  ir[20:16]
rd  out  5  ir[15:11]
shamt  out  5  ir[10:6]
funct  out  6  ir[5:0]
imm16  out  16  ir[15:0], to sign extender
jtarget  out  26  ir[25:0]

Behaviour:
- Reset (rst_n=0 at clock edge, any state):
  - pc=RESET_PC, ir=0, ir_valid=0, mem_req=0, mem_addr=0, busy=0, fault=0, wait counter=0, state=IDLE.
  - An in-flight fetch is abandoned. A mem_ack arriving after reset is ignored.
- States: IDLE, FETCH, FAULT. busy=1 exactly in FETCH.
- IDLE:
  - pc_write=1 loads pc <= {pc_next[31:2],2'b00}. The low two bits are always forced to zero.
  - fetch_start=1 moves to FETCH with mem_req=1, mem_addr=pc, ir_valid=0, wait counter=0.
  - pc_write and fetch_start in the same cycle: mem_addr = the aligned pc_next, and pc takes the same value.
- FETCH:
  - mem_req stays 1 and mem_addr stays stable until mem_ack.
  - mem_ack=1 at cycle M: at edge M+1, ir=mem_rdata, pc=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), ir_valid=1, mem_req=0, return to IDLE.
  - Minimum latency is fetch_start to ir_valid = 2 cycles, when mem_ack arrives in the first request cycle.
  - pc_write and fetch_start are ignored in FETCH; pc and ir are unchanged by them.
  - Each cycle without mem_ack increments the wait counter. If MAX_WAIT!=0 and the counter reaches MAX_WAIT with no ack, the next edge moves to FAULT, with mem_req=0 and fault=1.
  - mem_ack in the same cycle the counter reaches MAX_WAIT counts as success; no fault.
- FAULT:
  - Terminal until reset. mem_req=0, busy=0.
  - ir, ir_valid and pc hold their values. All inputs are ignored.
- mem_ack while in IDLE or FAULT is ignored.
- Fields and pc_plus4 are pure combinational slices of ir and pc. They change only when ir or pc changes.
- ir_valid stays 1 until the next accepted fetch_start or reset.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> pc=0, ir=0, ir_valid=0, mem_req=0, fault=0.
- Zero-wait fetch: fetch_start, with mem_ack on the first req cycle and mem_rdata=32'h2009_FFFC -> after 2 cycles ir_valid=1, pc=4, opcode=6'h08, rt=5'd9, imm16=16'hFFFC.
- Wait states: fetch with ack delayed 5 cycles -> mem_req=1 and mem_addr=4 held for all 6 request cycles, then ir latched and pc=8.
- Jump alignment and wrap:
  - pc_write with pc_next=32'hFFFF_FFFF -> pc=32'hFFFF_FFFC.
  - A fetch then yields mem_addr=32'hFFFF_FFFC and pc=0 after ack.
- Ignored commands: pc_write=1, pc_next=32'h100 during FETCH -> pc unchanged until ack, then pc=old+4.
- Watchdog: MAX_WAIT=16, no ack -> fault=1 and mem_req=0 after 16 wait cycles; a later ack has no effect. Reset mid-fetch (rst_n=0 on the 3rd request cycle) -> mem_req=0 and pc=RESET_PC.

Source files
------------

// File: rtl/ir_fetch_unit.sv
// Fetch stage: holds PC, runs a req/ack instruction-memory read, latches IR
// and exposes decode fields. A watchdog traps a memory that never acknowledges.
module ir_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        pc_write,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        busy,
  output logic        fault,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jtarget
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [31:0]       addr_q, addr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic [31:0]       pc_next_aligned;

  assign pc_next_aligned = {pc_next[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      addr_q     <= '0;
      wait_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    fault_d    = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (pc_write) pc_d = pc_next_aligned;
        if (fetch_start) begin
          state_d    = S_FETCH;
          addr_d     = pc_write ? pc_next_aligned : pc_q;
          ir_valid_d = 1'b0;
          wait_d     = '0;
        end
      end
      S_FETCH: begin
        // An ack in the cycle the counter hits the limit still wins over the fault.
        if (mem_ack) begin
          state_d    = S_IDLE;
          ir_d       = mem_rdata;
          pc_d       = pc_q + 32'd4;
          ir_valid_d = 1'b1;
        end else if ((MAX_WAIT != 0) && (wait_q == WAIT_LIMIT)) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req  = (state_q == S_FETCH);
  assign busy     = (state_q == S_FETCH);
  assign mem_addr = addr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign fault    = fault_q;
  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign jtarget  = ir_q[25:0];

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Directed bench for ir_fetch_unit: reset, fetch latency, wait states,
// alignment/wrap, ignored commands, watchdog fault and reset mid-fetch.
module tb_ir_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, fetch_start, pc_write, mem_ack;
  logic [31:0] pc_next, mem_rdata;
  logic        mem_req, ir_valid, busy, fault;
  logic [31:0] mem_addr, pc, pc_plus4, ir;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jtarget;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ir_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .MAX_WAIT(16),
    .WAIT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .pc(pc), .pc_plus4(pc_plus4), .ir(ir),
    .ir_valid(ir_valid), .busy(busy), .fault(fault), .opcode(opcode), .rs(rs),
    .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .jtarget(jtarget)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; fetch_start = 1'b0; pc_write = 1'b0; mem_ack = 1'b0;
    pc_next = '0; mem_rdata = '0;

    // Reset then idle
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_irv", ir_valid, 0);
    check("rst_req", mem_req, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("idle_pc", pc, 32'h0);
    check("idle_req", mem_req, 0);

    // Zero-wait fetch
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h2009_FFFC;
    check("zw_req", mem_req, 1);
    check("zw_addr", mem_addr, 32'h0);
    check("zw_busy", busy, 1);
    tick();
    mem_ack = 1'b0;
    check("zw_irv", ir_valid, 1);
    check("zw_pc", pc, 32'h4);
    check("zw_ir", ir, 32'h2009_FFFC);
    check("zw_opcode", opcode, 6'h08);
    check("zw_rs", rs, 5'd0);
    check("zw_rt", rt, 5'd9);
    check("zw_imm", imm16, 16'hFFFC);
    check("zw_pc4", pc_plus4, 32'h8);
    check("zw_req_off", mem_req, 0);
    check("zw_busy_off", busy, 0);

    // Wait states: ack delayed 5 cycles, 6 request cycles total
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("ws_irv_clr", ir_valid, 0);
    for (int i = 0; i < 5; i++) begin
      check("ws_req", mem_req, 1);
      check("ws_addr", mem_addr, 32'h4);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'h0123_4567;
    check("ws_req6", mem_req, 1);
    check("ws_addr6", mem_addr, 32'h4);
    tick();
    mem_ack = 1'b0;
    check("ws_ir", ir, 32'h0123_4567);
    check("ws_pc", pc, 32'h8);
    check("ws_rd", rd, 5'd8);
    check("ws_shamt", shamt, 5'd21);
    check("ws_funct", funct, 6'h27);
    check("ws_jt", jtarget, 26'h123_4567);

    // pc_write ignored during FETCH
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; pc_write = 1'b1; pc_next = 32'h100;
    tick();
    check("ign_pc1", pc, 32'h8);
    check("ign_addr", mem_addr, 32'h8);
    fetch_start = 1'b1;
    tick();
    check("ign_pc2", pc, 32'h8);
    fetch_start = 1'b0; pc_write = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check("ign_pc3", pc, 32'hC);
    check("ign_ir", ir, 32'hDEAD_BEEF);

    // mem_ack in IDLE ignored
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    check("idleack_ir", ir, 32'hDEAD_BEEF);
    check("idleack_pc", pc, 32'hC);
    check("idleack_irv", ir_valid, 1);

    // Jump alignment and wrap
    pc_write = 1'b1; pc_next = 32'hFFFF_FFFF;
    tick();
    pc_write = 1'b0;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = 32'h0800_0010;
    tick();
    mem_ack = 1'b0;
    check("wrap_pc0", pc, 32'h0);
    check("wrap_ir", ir, 32'h0800_0010);

    // pc_write and fetch_start together
    pc_write = 1'b1; fetch_start = 1'b1; pc_next = 32'h0000_0203;
    tick();
    pc_write = 1'b0; fetch_start = 1'b0;
    check("both_addr", mem_addr, 32'h200);
    check("both_pc", pc, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    mem_ack = 1'b0;
    check("both_pc2", pc, 32'h204);

    // Watchdog: 16 counted waits, ack still accepted on the 17th cycle, fault after it
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("wd_req", mem_req, 1);
      check("wd_nofault", fault, 0);
      tick();
    end
    check("wd_req17", mem_req, 1);
    tick();
    check("wd_fault", fault, 1);
    check("wd_req_off", mem_req, 0);
    check("wd_busy", busy, 0);
    check("wd_pc", pc, 32'h204);
    check("wd_irv", ir_valid, 0);
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333; fetch_start = 1'b1;
    pc_write = 1'b1; pc_next = 32'h400;
    tick(); tick();
    mem_ack = 1'b0; fetch_start = 1'b0; pc_write = 1'b0;
    check("flt_sticky", fault, 1);
    check("flt_pc", pc, 32'h204);
    check("flt_ir", ir, 32'hAAAA_5555);
    check("flt_req", mem_req, 0);

    // Reset mid-fetch on the 3rd request cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_fault", fault, 0);
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick(); tick();
    check("mid_req3", mem_req, 1);
    rst_n = 1'b0;
    tick();
    check("mid_req", mem_req, 0);
    check("mid_pc", pc, 32'h0);
    check("mid_busy", busy, 0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    check("mid_ir", ir, 32'h0);
    check("mid_irv", ir_valid, 0);
    check("mid_pc2", pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
